// File: rtl/tower_draw_scheduler.sv
// rtl/tower_draw_scheduler.sv - tower grid occupancy map and row-major redraw sequencer
// Keeps an 8x6 occupancy map, accepts placements, and steps the sprite drawer through occupied cells.
module tower_draw_scheduler #(
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       place_valid,
  input  logic [3:0] place_x,
  input  logic [3:0] place_y,
  input  logic       clear_all,
  input  logic       redraw_req,
  input  logic       draw_done,
  output logic [3:0] cell_x,
  output logic [3:0] cell_y,
  output logic       draw_start,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic       place_ok,
  output logic       place_err,
  output logic       draw_timeout
);
  localparam int CELLS = GRID_COLS * GRID_ROWS;
  localparam int IW    = $clog2(CELLS);
  localparam int TW    = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_map;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic [IW-1:0]    r_idx;
  logic [TW-1:0]    r_tcnt;
  logic             r_pending;
  logic             r_done_q;
  logic             r_draw_start;
  logic             r_plot;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_place_ok;
  logic             r_place_err;
  logic             r_timeout;

  logic             w_place_in;
  logic [IW-1:0]    w_place_idx;
  logic             w_place_acc;
  logic             w_last;
  logic             w_x_wrap;
  logic             w_occ;
  logic             w_rise;
  logic             w_expired;
  logic [3:0]       w_nx;
  logic [3:0]       w_ny;
  logic [IW-1:0]    w_nidx;

  // Out-of-range requests never touch the map, so the index may wrap harmlessly for them
  assign w_place_in  = (int'(place_x) < GRID_COLS) && (int'(place_y) < GRID_ROWS);
  assign w_place_idx = IW'(place_y) * IW'(GRID_COLS) + IW'(place_x);
  assign w_place_acc = place_valid && !clear_all && w_place_in && !r_map[w_place_idx];

  assign w_last    = (r_idx == IW'(CELLS - 1));
  assign w_x_wrap  = (r_x == 4'(GRID_COLS - 1));
  assign w_occ     = r_map[r_idx];
  assign w_rise    = draw_done && !r_done_q;
  assign w_expired = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_nx      = w_x_wrap ? 4'd0 : r_x + 4'd1;
  assign w_ny      = w_x_wrap ? r_y + 4'd1 : r_y;
  assign w_nidx    = r_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_map       <= '0;
      r_place_ok  <= 1'b0;
      r_place_err <= 1'b0;
    end else begin
      r_place_ok  <= w_place_acc;
      r_place_err <= place_valid && !w_place_acc;
      if (clear_all) begin
        r_map <= '0;
      end else if (w_place_acc) begin
        r_map[w_place_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_x          <= 4'd0;
      r_y          <= 4'd0;
      r_idx        <= '0;
      r_tcnt       <= '0;
      r_pending    <= 1'b0;
      r_done_q     <= 1'b0;
      r_draw_start <= 1'b0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done_q     <= draw_done;
      r_draw_start <= 1'b0;
      r_frame_done <= 1'b0;
      if (redraw_req && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (redraw_req || r_pending) begin
            r_state   <= S_SCAN;
            r_x       <= 4'd0;
            r_y       <= 4'd0;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_occ) begin
            r_state      <= S_LAUNCH;
            r_draw_start <= 1'b1;
          end else if (w_last) begin
            r_state      <= S_FINISH;
            r_frame_done <= 1'b1;
          end else begin
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_idx <= w_nidx;
          end
        end
        S_LAUNCH: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
          r_plot  <= 1'b1;
        end
        S_WAIT: begin
          // A hung drawer is abandoned exactly like a completed one so the frame still ends
          if (w_rise || w_expired) begin
            if (!w_rise) begin
              r_timeout <= 1'b1;
            end
            r_plot <= 1'b0;
            if (w_last) begin
              r_state      <= S_FINISH;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_SCAN;
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_idx   <= w_nidx;
            end
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_plot  <= 1'b0;
        end
      endcase
    end
  end

  assign cell_x       = r_x;
  assign cell_y       = r_y;
  assign draw_start   = r_draw_start;
  assign plot         = r_plot;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign place_ok     = r_place_ok;
  assign place_err    = r_place_err;
  assign draw_timeout = r_timeout;

endmodule

// File: tb/tb_tower_draw_scheduler.sv
// tb/tb_tower_draw_scheduler.sv - directed self-checking bench for tower_draw_scheduler
module tb_tower_draw_scheduler;
  logic       clk = 1'b0;
  logic       resetn;
  logic       place_valid;
  logic [3:0] place_x;
  logic [3:0] place_y;
  logic       clear_all;
  logic       redraw_req;
  logic       draw_done;
  logic [3:0] cell_x;
  logic [3:0] cell_y;
  logic       draw_start;
  logic       plot;
  logic       busy;
  logic       frame_done;
  logic       place_ok;
  logic       place_err;
  logic       draw_timeout;

  tower_draw_scheduler dut (
    .clk          (clk),
    .resetn       (resetn),
    .place_valid  (place_valid),
    .place_x      (place_x),
    .place_y      (place_y),
    .clear_all    (clear_all),
    .redraw_req   (redraw_req),
    .draw_done    (draw_done),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .draw_start   (draw_start),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done),
    .place_ok     (place_ok),
    .place_err    (place_err),
    .draw_timeout (draw_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int drw_cnt = 0;
  int drw_delay = 402;
  bit drw_en = 1'b1;
  int n_start;
  int n_plot;
  int n_busy;
  int n_frame;
  int start_cyc[$];
  logic [7:0] start_cell[$];
  int frame_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; drawer model and output statistics are updated after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (draw_start) begin
      draw_done = 1'b0;
      drw_cnt = drw_delay;
    end else if (drw_cnt > 0) begin
      drw_cnt--;
      if (drw_cnt == 0 && drw_en) draw_done = 1'b1;
    end
    if (draw_start) begin
      n_start++;
      start_cyc.push_back(cyc);
      start_cell.push_back({cell_x, cell_y});
    end
    if (plot) n_plot++;
    if (busy) n_busy++;
    if (frame_done) begin
      n_frame++;
      frame_cyc.push_back(cyc);
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic clr_stats();
    n_start = 0;
    n_plot = 0;
    n_busy = 0;
    n_frame = 0;
    start_cyc.delete();
    start_cell.delete();
    frame_cyc.delete();
  endtask

  task automatic place(input int x, input int y, input bit exp_ok, input string tag);
    place_valid = 1'b1;
    place_x = 4'(x);
    place_y = 4'(y);
    step();
    place_valid = 1'b0;
    check({tag, "_ok"}, place_ok, exp_ok);
    check({tag, "_err"}, place_err, !exp_ok);
  endtask

  task automatic redraw(output int n);
    redraw_req = 1'b1;
    n = cyc;
    step();
    redraw_req = 1'b0;
  endtask

  task automatic clear_map();
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
  endtask

  task automatic wait_plot(input string tag);
    int k = 0;
    while (!plot && k < 100) begin
      step();
      k++;
    end
    check(tag, plot, 1);
  endtask

  int n;

  initial begin
    resetn = 1'b0;
    place_valid = 1'b0;
    place_x = 4'd0;
    place_y = 4'd0;
    clear_all = 1'b0;
    redraw_req = 1'b0;
    draw_done = 1'b0;
    clr_stats();
    run(3);
    check("rst_busy", busy, 0);
    check("rst_plot", plot, 0);
    check("rst_start", draw_start, 0);
    check("rst_frame", frame_done, 0);
    check("rst_ok", place_ok, 0);
    check("rst_err", place_err, 0);
    check("rst_tmo", draw_timeout, 0);
    check("rst_cell", {cell_x, cell_y}, 0);
    resetn = 1'b1;
    step();

    // Empty map: frame_done at n+49, busy 49 cycles, no launches
    clr_stats();
    redraw(n);
    run(60);
    check("t1_starts", n_start, 0);
    check("t1_busy_cycles", n_busy, 49);
    check("t1_frames", n_frame, 1);
    check("t1_frame_cyc", (frame_cyc.size() > 0) ? frame_cyc[0] - n : -1, 49);

    // Single tower at (2,1), drawer takes 402 cycles
    place(2, 1, 1'b1, "t2_place");
    step();
    check("t2_ok_pulse", place_ok, 0);
    clr_stats();
    drw_delay = 402;
    redraw(n);
    run(600);
    check("t2_starts", n_start, 1);
    check("t2_cell", (start_cell.size() > 0) ? start_cell[0] : 8'hFF, 8'h21);
    check("t2_start_cyc", (start_cyc.size() > 0) ? start_cyc[0] - n : -1, 12);
    check("t2_plot_cycles", n_plot, 402);
    check("t2_frames", n_frame, 1);
    check("t2_frame_cyc", (frame_cyc.size() > 0) ? frame_cyc[0] - n : -1, 452);
    check("t2_busy_cycles", n_busy, 452);
    check("t2_tmo", draw_timeout, 0);

    // Placement legality and clear priority
    clear_all = 1'b1;
    place(3, 3, 1'b0, "t3_clr_prio");
    clear_all = 1'b0;
    place(8, 0, 1'b0, "t3_x_range");
    place(0, 6, 1'b0, "t3_y_range");
    place(2, 1, 1'b1, "t3_first");
    place(2, 1, 1'b0, "t3_dup");
    clr_stats();
    drw_delay = 10;
    redraw(n);
    run(150);
    check("t3_starts", n_start, 1);
    check("t3_cell", (start_cell.size() > 0) ? start_cell[0] : 8'hFF, 8'h21);

    // Two towers, redraw requested mid-draw collapses into one rescan
    clear_map();
    place(0, 0, 1'b1, "t4_p00");
    place(7, 5, 1'b1, "t4_p75");
    clr_stats();
    redraw(n);
    wait_plot("t4_wait_plot");
    redraw_req = 1'b1;
    step();
    redraw_req = 1'b0;
    run(300);
    check("t4_starts", n_start, 4);
    check("t4_cell0", (start_cell.size() > 0) ? start_cell[0] : 8'hFF, 8'h00);
    check("t4_cell1", (start_cell.size() > 1) ? start_cell[1] : 8'hFF, 8'h75);
    check("t4_cell2", (start_cell.size() > 2) ? start_cell[2] : 8'hFF, 8'h00);
    check("t4_cell3", (start_cell.size() > 3) ? start_cell[3] : 8'hFF, 8'h75);
    check("t4_frames", n_frame, 2);
    check("t4_frame1_cyc", (frame_cyc.size() > 0) ? frame_cyc[0] - n : -1, 71);
    check("t4_rescan_gap", (frame_cyc.size() > 0 && start_cyc.size() > 2) ?
          start_cyc[2] - frame_cyc[0] : -1, 3);

    // Drawer never completes
    clear_map();
    place(1, 0, 1'b1, "t5_place");
    drw_en = 1'b0;
    clr_stats();
    redraw(n);
    run(1200);
    check("t5_tmo", draw_timeout, 1);
    check("t5_plot_cycles", n_plot, 1024);
    check("t5_starts", n_start, 1);
    check("t5_frames", n_frame, 1);
    check("t5_frame_cyc", (frame_cyc.size() > 0) ? frame_cyc[0] - n : -1, 1074);
    run(5);
    check("t5_tmo_sticky", draw_timeout, 1);
    drw_en = 1'b1;

    // Reset during WAIT
    drw_delay = 402;
    clear_map();
    place(0, 0, 1'b1, "t6_place");
    clr_stats();
    redraw(n);
    wait_plot("t6_wait_plot");
    run(5);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    drw_cnt = 0;
    draw_done = 1'b0;
    check("t6_plot", plot, 0);
    check("t6_busy", busy, 0);
    check("t6_tmo", draw_timeout, 0);
    check("t6_start", draw_start, 0);
    clr_stats();
    redraw(n);
    run(60);
    check("t6_starts", n_start, 0);
    check("t6_frames", n_frame, 1);
    check("t6_frame_cyc", (frame_cyc.size() > 0) ? frame_cyc[0] - n : -1, 49);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
